hazard_ctrl: RTL and testbench

//  Pipeline control for the 5-stage rv32i core: the producer of the en/clr pairs consumed by

---
 rtl/hazard_ctrl_pkg.sv | 18 +
 rtl/hazard_ctrl_fwd_sel.sv | 28 ++
 rtl/hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_hazard_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the rv32i pipeline hazard controller: forwarding selects and the
// data-memory wait state encoding.
package hazard_ctrl_pkg;

   localparam int REG_AW = 5;

   typedef enum logic [1:0] {
      FWD_NONE = 2'd0,
      FWD_W    = 2'd1,
      FWD_M    = 2'd2
   } fwd_sel_e;

   typedef enum logic {
      MEM_IDLE = 1'b0,
      MEM_WAIT = 1'b1
   } mem_state_e;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// E-stage operand forwarding select for one source register; M beats W.
// Macro FORWARDING_EN: when undefined the select is tied to FWD_NONE.
module fwd_sel
   import hazard_ctrl_pkg::*;
#(
   parameter int AW = 5
) (
   input  logic [AW-1:0] i_rs,
   input  logic [AW-1:0] i_rd_m,
   input  logic [AW-1:0] i_rd_w,
   input  logic          i_regwrite_m,
   input  logic          i_regwrite_w,
   output fwd_sel_e      o_sel
);

`ifdef FORWARDING_EN
   always_comb begin
      o_sel = FWD_NONE;
      if (i_regwrite_w && (i_rd_w != '0) && (i_rd_w == i_rs)) o_sel = FWD_W;
      if (i_regwrite_m && (i_rd_m != '0) && (i_rd_m == i_rs)) o_sel = FWD_M;
   end
`else
   logic w_unused_fwd;
   assign w_unused_fwd = ^{i_rs, i_rd_m, i_rd_w, i_regwrite_m, i_regwrite_w};
   assign o_sel = FWD_NONE;
`endif

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline en/clr generation, hazard detection, dmem wait freeze and stall-cycle counter.
// Macro FORWARDING_EN: enables E-stage forwarding; otherwise RAW hazards stall in D.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_AW = hazard_ctrl_pkg::REG_AW,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] rs1_d,
   input  logic [REG_AW-1:0] rs2_d,
   input  logic [REG_AW-1:0] rs1_e,
   input  logic [REG_AW-1:0] rs2_e,
   input  logic [REG_AW-1:0] rd_e,
   input  logic [REG_AW-1:0] rd_m,
   input  logic [REG_AW-1:0] rd_w,
   input  logic              regwrite_e,
   input  logic              regwrite_m,
   input  logic              regwrite_w,
   input  logic              load_e,
   input  logic              pcsrc_e,
   input  logic              dmem_req_m,
   input  logic              dmem_ready,
   output logic              en_f,
   output logic              en_d,
   output logic              en_e,
   output logic              en_m,
   output logic              en_w,
   output logic              clr_d,
   output logic              clr_e,
   output logic              clr_m,
   output fwd_sel_e          fwd_a_e,
   output fwd_sel_e          fwd_b_e,
   output logic [CNT_W-1:0]  stall_cycles
);

   mem_state_e       r_mem_state;
   mem_state_e       w_mem_state_nxt;
   logic [CNT_W-1:0] r_stall_cycles;
   fwd_sel_e         w_fwd_a;
   fwd_sel_e         w_fwd_b;
   logic             w_freeze;
   logic             w_load_use;
   logic             w_stall;

   function automatic logic dep(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs);
      return (rd != '0) && (rd == rs);
   endfunction

   fwd_sel #(.AW(REG_AW)) u_fwd_a (
      .i_rs(rs1_e), .i_rd_m(rd_m), .i_rd_w(rd_w),
      .i_regwrite_m(regwrite_m), .i_regwrite_w(regwrite_w), .o_sel(w_fwd_a)
   );

   fwd_sel #(.AW(REG_AW)) u_fwd_b (
      .i_rs(rs2_e), .i_rd_m(rd_m), .i_rd_w(rd_w),
      .i_regwrite_m(regwrite_m), .i_regwrite_w(regwrite_w), .o_sel(w_fwd_b)
   );

   assign w_load_use = load_e && (dep(rd_e, rs1_d) || dep(rd_e, rs2_d));

`ifdef FORWARDING_EN
   logic w_unused_we;
   assign w_unused_we = regwrite_e;
   assign w_stall     = w_load_use;
`else
   // Without bypass paths any in-flight E/M writer of a D source must drain first.
   assign w_stall = w_load_use
                 || (regwrite_e && (dep(rd_e, rs1_d) || dep(rd_e, rs2_d)))
                 || (regwrite_m && (dep(rd_m, rs1_d) || dep(rd_m, rs2_d)));
`endif

   always_ff @(posedge clk) begin
      if (rst) r_mem_state <= MEM_IDLE;
      else     r_mem_state <= w_mem_state_nxt;
   end

   always_comb begin
      w_mem_state_nxt = r_mem_state;
      case (r_mem_state)
         MEM_IDLE: if (dmem_req_m && !dmem_ready) w_mem_state_nxt = MEM_WAIT;
         MEM_WAIT: if (dmem_ready)                w_mem_state_nxt = MEM_IDLE;
         default:                                 w_mem_state_nxt = MEM_IDLE;
      endcase
   end

   always_comb begin
      w_freeze = ((r_mem_state == MEM_IDLE) && dmem_req_m && !dmem_ready)
              || ((r_mem_state == MEM_WAIT) && !dmem_ready);
      en_f    = 1'b1;
      en_d    = 1'b1;
      en_e    = 1'b1;
      en_m    = 1'b1;
      en_w    = 1'b1;
      clr_d   = 1'b0;
      clr_e   = 1'b0;
      clr_m   = 1'b0;
      fwd_a_e = w_fwd_a;
      fwd_b_e = w_fwd_b;
      if (rst) begin
         fwd_a_e = FWD_NONE;
         fwd_b_e = FWD_NONE;
      end else if (w_freeze) begin
         // Clears stay low: a stage flop's clear would override its disabled enable.
         {en_f, en_d, en_e, en_m, en_w} = 5'b00000;
      end else if (pcsrc_e) begin
         clr_d = 1'b1;
         clr_e = 1'b1;
      end else if (w_stall) begin
         en_f  = 1'b0;
         en_d  = 1'b0;
         clr_e = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                                    r_stall_cycles <= '0;
      else if (!en_d && (r_stall_cycles != '1))   r_stall_cycles <= r_stall_cycles + CNT_W'(1);
   end

   assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, dmem-wait sequence and
// randomized traffic against a behavioural model. Honours FORWARDING_EN like the design.
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   localparam int CW = 4;
`ifdef FORWARDING_EN
   localparam bit FWD_ON = 1'b1;
`else
   localparam bit FWD_ON = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [4:0]    rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic          regwrite_e, regwrite_m, regwrite_w, load_e, pcsrc_e, dmem_req_m, dmem_ready;
   logic          en_f, en_d, en_e, en_m, en_w, clr_d, clr_e, clr_m;
   fwd_sel_e      fwd_a_e, fwd_b_e;
   logic [CW-1:0] stall_cycles;

   hazard_ctrl #(.REG_AW(5), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
      .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
      .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
      .load_e(load_e), .pcsrc_e(pcsrc_e), .dmem_req_m(dmem_req_m), .dmem_ready(dmem_ready),
      .en_f(en_f), .en_d(en_d), .en_e(en_e), .en_m(en_m), .en_w(en_w),
      .clr_d(clr_d), .clr_e(clr_e), .clr_m(clr_m),
      .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .stall_cycles(stall_cycles)
   );

   typedef struct packed {
      logic       rst;
      logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
      logic       rwe, rwm, rww, load_e, pcsrc, req, rdy;
      logic [4:0] exp_en;   // {f,d,e,m,w}
      logic [2:0] exp_clr;  // {d,e,m}
      logic [1:0] exp_fa, exp_fb;
   } vec_t;

   typedef struct packed {
      logic [4:0] en;
      logic [2:0] clr;
      logic [1:0] fa, fb;
   } exp_t;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference state: whether a dmem access is outstanding, and the stall count.
   bit      m_waiting = 1'b0;
   int      m_cnt     = 0;
   localparam int CMAX = (1 << CW) - 1;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] fwd_of(input logic [4:0] rs);
      if (!FWD_ON)                                      return 2'd0;
      if (regwrite_m && rd_m != 0 && rd_m == rs)        return 2'd2;
      if (regwrite_w && rd_w != 0 && rd_w == rs)        return 2'd1;
      return 2'd0;
   endfunction

   function automatic bit hits(input logic [4:0] rd);
      return rd != 0 && (rd == rs1_d || rd == rs2_d);
   endfunction

   function automatic exp_t model();
      exp_t e;
      bit   frozen, stall;
      e.en = 5'b11111; e.clr = 3'b000; e.fa = 2'd0; e.fb = 2'd0;
      if (rst) return e;
      e.fa   = fwd_of(rs1_e);
      e.fb   = fwd_of(rs2_e);
      frozen = m_waiting ? !dmem_ready : (dmem_req_m && !dmem_ready);
      stall  = (load_e && hits(rd_e))
            || (!FWD_ON && ((regwrite_e && hits(rd_e)) || (regwrite_m && hits(rd_m))));
      if (frozen)       e.en = 5'b00000;
      else if (pcsrc_e) e.clr = 3'b110;
      else if (stall) begin e.en = 5'b00111; e.clr = 3'b010; end
      return e;
   endfunction

   task automatic model_tick(input exp_t e);
      if (rst) begin
         m_waiting = 1'b0;
         m_cnt     = 0;
      end else begin
         if (!e.en[3] && m_cnt < CMAX) m_cnt++;
         if (!m_waiting && dmem_req_m && !dmem_ready) m_waiting = 1'b1;
         else if (m_waiting && dmem_ready)            m_waiting = 1'b0;
      end
   endtask

   task automatic drive(input vec_t v);
      rst = v.rst;
      rs1_d = v.rs1_d; rs2_d = v.rs2_d; rs1_e = v.rs1_e; rs2_e = v.rs2_e;
      rd_e = v.rd_e; rd_m = v.rd_m; rd_w = v.rd_w;
      regwrite_e = v.rwe; regwrite_m = v.rwm; regwrite_w = v.rww;
      load_e = v.load_e; pcsrc_e = v.pcsrc; dmem_req_m = v.req; dmem_ready = v.rdy;
   endtask

   task automatic check_outs(input string nm, input exp_t e);
      cmp({nm, "_en"},  {27'd0, en_f, en_d, en_e, en_m, en_w}, {27'd0, e.en});
      cmp({nm, "_clr"}, {29'd0, clr_d, clr_e, clr_m},          {29'd0, e.clr});
      cmp({nm, "_fa"},  {30'd0, fwd_a_e},                      {30'd0, e.fa});
      cmp({nm, "_fb"},  {30'd0, fwd_b_e},                      {30'd0, e.fb});
      cmp({nm, "_cnt"}, {28'd0, stall_cycles},                 32'(m_cnt));
   endtask

   // One cycle: inputs settle, outputs checked mid-cycle, then the edge advances the model.
   task automatic cycle(input string nm, input exp_t e);
      exp_t me;
      @(negedge clk);
      me = model();
      check_outs(nm, e);
      @(posedge clk);
      model_tick(me);
      #1;
   endtask

   vec_t tbl[12];
   vec_t v;
   exp_t e;

   initial begin
      // Row 0/1: reset with every hazard input asserted.
      v = '0; v.rst = 1; v.load_e = 1; v.rwe = 1; v.rd_e = 5; v.rs1_d = 5; v.pcsrc = 1;
      v.req = 1; v.rdy = 0; v.rwm = 1; v.rd_m = 7; v.rs1_e = 7; v.rww = 1; v.rd_w = 7;
      v.exp_en = 5'h1f;
      tbl[0] = v; tbl[1] = v;
      // Load-use: one bubble, then the load has moved on.
      v = '0; v.rdy = 1; v.load_e = 1; v.rwe = 1; v.rd_e = 5; v.rs1_d = 5;
      v.exp_en = 5'b00111; v.exp_clr = 3'b010; tbl[2] = v;
      v = '0; v.rdy = 1; v.exp_en = 5'h1f; tbl[3] = v;
      // Forwarding priority M > W, x0 never forwarded.
      v = '0; v.rdy = 1; v.rwm = 1; v.rd_m = 7; v.rww = 1; v.rd_w = 7; v.rs1_e = 7;
      v.exp_en = 5'h1f; v.exp_fa = FWD_ON ? 2'd2 : 2'd0; tbl[4] = v;
      v.rd_m = 0; v.exp_fa = FWD_ON ? 2'd1 : 2'd0; tbl[5] = v;
      v.rs1_e = 0; v.exp_fa = 2'd0; tbl[6] = v;
      v = '0; v.rdy = 1; v.rwm = 1; v.rd_m = 7; v.rs2_e = 7; v.rs1_e = 3;
      v.exp_en = 5'h1f; v.exp_fb = FWD_ON ? 2'd2 : 2'd0; tbl[7] = v;
      // Redirect overrides a simultaneous load-use stall.
      v = '0; v.rdy = 1; v.pcsrc = 1; v.load_e = 1; v.rwe = 1; v.rd_e = 9; v.rs2_d = 9;
      v.exp_en = 5'h1f; v.exp_clr = 3'b110; tbl[8] = v;
      // M-stage RAW against D: stall only without forwarding.
      v = '0; v.rdy = 1; v.rwm = 1; v.rd_m = 3; v.rs2_d = 3;
      v.exp_en = FWD_ON ? 5'h1f : 5'b00111; v.exp_clr = FWD_ON ? 3'b000 : 3'b010; tbl[9] = v;
      v = '0; v.rdy = 1; v.exp_en = 5'h1f; tbl[10] = v;
      // x0 destination never creates a hazard.
      v = '0; v.rdy = 1; v.load_e = 1; v.rwe = 1; v.rd_e = 0; v.rs1_d = 0;
      v.exp_en = 5'h1f; tbl[11] = v;

      drive(tbl[0]);
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) begin
         drive(tbl[i]);
         e.en = tbl[i].exp_en; e.clr = tbl[i].exp_clr;
         e.fa = tbl[i].exp_fa; e.fb = tbl[i].exp_fb;
         cycle($sformatf("tbl%0d", i), e);
      end

      // dmem wait for three cycles with a pending redirect, then release.
      v = '0; v.req = 1; v.rdy = 0; v.pcsrc = 1; drive(v);
      e = '0;
      for (int i = 0; i < 3; i++) cycle($sformatf("wait%0d", i), e);
      dmem_ready = 1'b1;
      e.en = 5'h1f; e.clr = 3'b110;
      cycle("release", e);
      v = '0; v.rdy = 1; drive(v);
      e.en = 5'h1f; e.clr = 3'b000;
      cycle("idle", e);

      // Randomized traffic; small register range to make matches common.
      for (int i = 0; i < 600; i++) begin
         rst        = ($urandom_range(0, 60) == 0);
         rs1_d      = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
         rs1_e      = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
         rd_e       = 5'($urandom_range(0, 3)); rd_m  = 5'($urandom_range(0, 3));
         rd_w       = 5'($urandom_range(0, 3));
         regwrite_e = 1'($urandom_range(0, 1)); regwrite_m = 1'($urandom_range(0, 1));
         regwrite_w = 1'($urandom_range(0, 1)); load_e     = 1'($urandom_range(0, 1));
         pcsrc_e    = ($urandom_range(0, 3) == 0);
         dmem_req_m = ($urandom_range(0, 2) == 0);
         dmem_ready = ($urandom_range(0, 2) != 0);
         #1;
         cycle("rnd", model());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
